// File: rtl/test_gate_pkg.sv
// rtl/test_gate_pkg.sv - shared truth-table constants and helpers for test_gate
package test_gate_pkg;

  localparam logic [3:0] LUT_AND  = 4'b1000;
  localparam logic [3:0] LUT_OR   = 4'b1110;
  localparam logic [3:0] LUT_XOR  = 4'b0110;
  localparam logic [3:0] LUT_NAND = 4'b0111;
  localparam logic [3:0] LUT_NOR  = 4'b0001;
  localparam logic [3:0] LUT_XNOR = 4'b1001;

  localparam int CNT_W_DEF = 16;

  // Truth table is indexed with a as the MSB of the select.
  function automatic logic lut_eval(input logic [3:0] lut, input logic a, input logic b);
    return lut[{a, b}];
  endfunction

endpackage

// File: rtl/test_gate_checker.sv
// rtl/test_gate_checker.sv - compares gate output against expected value, counts vectors and errors
module test_gate_checker
  import test_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             y,
  input  logic             exp,
  output logic             err,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic             err_q, err_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             mismatch;

  always_comb begin
    mismatch  = (y != exp);
    err_d     = err_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    if (in_valid) begin
      err_d = mismatch;
      // Counters stick at all-ones rather than wrapping.
      if (!(&vec_cnt_q)) vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (mismatch && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/test_gate.sv
// rtl/test_gate.sv - programmable 2-input gate with registered copy; checker built in under TEST_GATE_CHECK_EN
module test_gate
  import test_gate_pkg::*;
#(
  parameter logic [3:0] DEFAULT_LUT = LUT_XOR,
  parameter int         CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             y,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_lut,
  input  logic             in_valid,
  input  logic             exp,
  output logic             y_q,
  output logic             err,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [3:0] lut_q, lut_d;
  logic       y_q_d;

  // y reads the current table, so a same-cycle write only takes effect next cycle.
  always_comb begin
    y     = lut_eval(lut_q, a, b);
    y_q_d = y;
    lut_d = cfg_we ? cfg_lut : lut_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q <= DEFAULT_LUT;
      y_q   <= 1'b0;
    end else begin
      lut_q <= lut_d;
      y_q   <= y_q_d;
    end
  end

`ifdef TEST_GATE_CHECK_EN
  test_gate_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .y        (y),
    .exp      (exp),
    .err      (err),
    .vec_cnt  (vec_cnt),
    .err_cnt  (err_cnt)
  );
`else
  logic unused_chk_inputs;
  assign unused_chk_inputs = &{1'b0, in_valid, exp};
  assign err     = 1'b0;
  assign vec_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_test_gate.sv
// tb/tb_test_gate.sv - directed self-checking bench for test_gate
module tb_test_gate;
  import test_gate_pkg::*;

`ifdef TEST_GATE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a, b, cfg_we, in_valid, exp;
  logic [3:0]  cfg_lut;
  logic        y, y_q, err;
  logic [15:0] vec_cnt, err_cnt;

  logic        s_a, s_b, s_valid, s_exp;
  logic        s_y, s_y_q, s_err;
  logic [3:0]  s_vec_cnt, s_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  test_gate dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(y),
    .cfg_we(cfg_we), .cfg_lut(cfg_lut), .in_valid(in_valid), .exp(exp),
    .y_q(y_q), .err(err), .vec_cnt(vec_cnt), .err_cnt(err_cnt)
  );

  test_gate #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(s_a), .b(s_b), .y(s_y),
    .cfg_we(1'b0), .cfg_lut(4'b0000), .in_valid(s_valid), .exp(s_exp),
    .y_q(s_y_q), .err(s_err), .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int v, input int e, input bit er);
    check_val({tag, " vec_cnt"}, 32'(vec_cnt), CHK_EN ? 32'(v) : 32'd0);
    check_val({tag, " err_cnt"}, 32'(err_cnt), CHK_EN ? 32'(e) : 32'd0);
    check_val({tag, " err"},     32'(err),     CHK_EN ? 32'(er) : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b1; b = 1'b0; cfg_we = 1'b0; cfg_lut = 4'h0;
    in_valid = 1'b0; exp = 1'b0;
    s_a = 1'b0; s_b = 1'b0; s_valid = 1'b0; s_exp = 1'b0;
    #12;
    check_val("reset y_q", 32'(y_q), 32'd0);
    check_val("reset y xor 10", 32'(y), 32'd1);
    check_cnt("reset", 0, 0, 1'b0);
    rst_n = 1'b1;
    step();

    // Default XOR sweep, all matching
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      logic [3:0] tbl;
      ab = 2'(i);
      tbl = 4'b0110;
      a = ab[1]; b = ab[0]; exp = tbl[i]; in_valid = 1'b1;
      #1;
      check_val($sformatf("xor y %0d", i), 32'(y), 32'(tbl[i]));
      step();
      check_val($sformatf("xor y_q %0d", i), 32'(y_q), 32'(tbl[i]));
    end
    check_cnt("xor sweep", 4, 0, 1'b0);

    // Single mismatch, then a matching vector clears err
    a = 1'b1; b = 1'b1; exp = 1'b1;
    step();
    check_cnt("mismatch", 5, 1, 1'b1);
    a = 1'b0; b = 1'b1; exp = 1'b1;
    step();
    check_cnt("recover", 6, 1, 1'b0);

    // Reprogram to AND with a coincident vector checked against the old XOR table
    cfg_we = 1'b1; cfg_lut = LUT_AND; a = 1'b1; b = 1'b1; exp = 1'b0;
    #1;
    check_val("old lut y", 32'(y), 32'd0);
    step();
    check_cnt("reprogram", 7, 1, 1'b0);
    cfg_we = 1'b0; in_valid = 1'b0;
    #1;
    check_val("and y 11", 32'(y), 32'd1);
    step();
    check_val("and y_q", 32'(y_q), 32'd1);
    check_cnt("hold", 7, 1, 1'b0);

    // Async reset mid-operation, then rebuild vec_cnt=3 with an OR table
    #3 rst_n = 1'b0;
    #1;
    check_cnt("async rst1", 0, 0, 1'b0);
    check_val("async rst1 y xor 11", 32'(y), 32'd0);
    #1 rst_n = 1'b1;
    step();
    cfg_we = 1'b1; cfg_lut = LUT_OR;
    step();
    cfg_we = 1'b0; in_valid = 1'b1;
    a = 1'b0; b = 1'b0; exp = 1'b0; step();
    a = 1'b0; b = 1'b1; exp = 1'b1; step();
    a = 1'b1; b = 1'b0; exp = 1'b0; step();
    in_valid = 1'b0; a = 1'b1; b = 1'b1;
    #1;
    check_val("or y 11", 32'(y), 32'd1);
    check_val("or y_q", 32'(y_q), 32'd1);
    check_cnt("pre rst", 3, 1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_cnt("async rst2", 0, 0, 1'b0);
    check_val("async rst2 y_q", 32'(y_q), 32'd0);
    check_val("async rst2 y xor 11", 32'(y), 32'd0);
    #1 rst_n = 1'b1;
    step();

    // Saturation on the 4-bit instance: 20 mismatching vectors (XOR 00 -> 0, exp 1)
    s_a = 1'b0; s_b = 1'b0; s_exp = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) begin
        check_val("sat vec_cnt @15", 32'(s_vec_cnt), CHK_EN ? 32'd15 : 32'd0);
      end
    end
    s_valid = 1'b0;
    check_val("sat vec_cnt", 32'(s_vec_cnt), CHK_EN ? 32'd15 : 32'd0);
    check_val("sat err_cnt", 32'(s_err_cnt), CHK_EN ? 32'd15 : 32'd0);
    check_val("sat err",     32'(s_err),     CHK_EN ? 32'd1 : 32'd0);
    check_val("sat y",       32'(s_y), 32'd0);
    check_cnt("main idle", 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/test_gate.md
TEST_GATE -- requirements
Module: test_gate

Interface
REQ-001 Parameter DEFAULT_LUT, 4'b0110, truth table loaded at reset; bit index {a,b}, so the default is XOR.
REQ-002 Parameter CNT_W, 16, width of the vector and error counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  1  first operand.
REQ-006 b  input  1  second operand.
REQ-007 y  output  1  combinational result, lut[{a,b}].
REQ-008 cfg_we  input  1  truth-table write strobe.
REQ-009 cfg_lut  input  4  new truth table; written when cfg_we=1.
REQ-010 in_valid  input  1  current a/b/exp form a vector to be checked this cycle.
REQ-011 exp  input  1  expected y for the current vector.
REQ-012 y_q  output  1  y registered on each clock edge.
REQ-013 err  output  1  registered flag: the last checked vector mismatched.
REQ-014 vec_cnt  output  CNT_W  number of vectors checked.
REQ-015 err_cnt  output  CNT_W  number of mismatching vectors.

Function
REQ-016 y SHALL equal lut[{a,b}] with zero cycles of latency and no clock dependence; any a/b change appears on y within the same delta/settle.
REQ-017 lut SHALL load cfg_lut on a rising edge with cfg_we=1 and hold its value otherwise.
REQ-018 When cfg_we and in_valid coincide, y and the check SHALL use the old lut; the new lut applies from the next cycle.
REQ-019 y_q SHALL capture y on every rising edge, giving one cycle of latency.
REQ-020 On a rising edge with in_valid=1, vec_cnt SHALL increment by 1.
REQ-021 On that edge, err SHALL be set to (y != exp).
REQ-022 On that edge, err_cnt SHALL increment by 1 if y != exp.
REQ-023 With in_valid=0, err, vec_cnt and err_cnt SHALL hold.
REQ-024 vec_cnt and err_cnt SHALL saturate at all-ones and never wrap.
REQ-025 An X/Z value on a, b or exp is outside the contract; no X-propagation handling is required.

Reset
REQ-026 While rst_n=0, the following SHALL hold: lut=DEFAULT_LUT, y_q=0, err=0, vec_cnt=0, err_cnt=0.
REQ-027 Assertion of rst_n SHALL take effect immediately, asynchronously and mid-operation.
REQ-028 Deassertion of rst_n SHALL be synchronous to clk; the first update is on the first rising edge with rst_n=1.
REQ-029 y SHALL remain combinational during reset, using DEFAULT_LUT.

Configuration
REQ-030 When macro TEST_GATE_CHECK_EN is defined, the checker logic of REQ-020 to REQ-024 SHALL be compiled in.
REQ-031 When TEST_GATE_CHECK_EN is undefined:
- the ports err, vec_cnt and err_cnt SHALL remain present and be tied to 0;
- in_valid and exp SHALL be ignored;
- y, y_q and lut behaviour SHALL be unchanged.

Structure
REQ-032 Package test_gate_pkg SHALL hold the LUT constants LUT_AND=4'b1000, LUT_OR=4'b1110, LUT_XOR=4'b0110, LUT_NAND=4'b0111, LUT_NOR=4'b0001 and LUT_XNOR=4'b1001.
REQ-033 test_gate_pkg SHALL also hold the default CNT_W.
REQ-034 The checker SHALL be one sub-module, test_gate_checker (ports: clk, rst_n, in_valid, y, exp, err, vec_cnt, err_cnt), instantiated only under TEST_GATE_CHECK_EN.

Verification
REQ-035 Default XOR: reset, then apply {a,b}=00,01,10,11 with exp=0,1,1,0 and in_valid=1 -> y=0,1,1,0; vec_cnt=4, err_cnt=0, err=0.
REQ-036 Mismatch: XOR table, a=1, b=1, exp=1, in_valid=1 for one cycle -> err=1 and err_cnt=1 after the edge; next matching vector -> err=0, err_cnt remains 1.
REQ-037 Reprogram: cfg_we=1, cfg_lut=LUT_AND, with in_valid=1, a=1, b=1, exp=0 in the same cycle -> no error (old XOR table used); next cycle a=1, b=1 gives y=1.
REQ-038 Saturation: CNT_W=4, 20 valid mismatching vectors -> vec_cnt=15 and err_cnt=15, no wrap.
REQ-039 Async reset: with vec_cnt=3 and lut=LUT_OR, assert rst_n=0 between edges -> counters=0, err=0, y_q=0 and lut=XOR immediately, without waiting for a clock edge.
REQ-040 Macro off: build without TEST_GATE_CHECK_EN and drive mismatching vectors -> err, vec_cnt and err_cnt stay 0 while y is still correct.
